// File: rtl/seg_msg_pkg.sv
// seg_msg_pkg: shared types and constants for the scrolling seven-segment
// message buffer.
//   seg_t   - one active-low hgfedcba segment byte (0 = segment lit)
//   state_t - load controller states
// Optional feature macro used by the RTL: SEG_MSG_PERIOD_MERGE_EN
package seg_msg_pkg;

    typedef logic [7:0] seg_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit
    } state_t;

    localparam seg_t       SEG_BLANK   = 8'hFF;
    localparam seg_t       SEG_DP_MASK = 8'h80;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam logic [7:0] CHAR_PERIOD = 8'h2E;

endpackage

// File: rtl/seg_font.sv
// seg_font: combinational ASCII to active-low seven-segment glyph lookup.
// Ports:
//   ascii - input ASCII byte
//   seg   - active-low hgfedcba pattern; unsupported codes give all-off (0xFF)
// Letters use the closest displayable glyph; lower-case letters share the
// upper-case glyph unless a distinct lower-case form reads better.
module seg_font
    import seg_msg_pkg::*;
(
    input  logic [7:0] ascii,
    output seg_t       seg
);

    logic [7:0] upper;

    always_comb begin
        seg   = SEG_BLANK;
        upper = ((ascii >= "a") && (ascii <= "z")) ? (ascii - 8'h20) : ascii;

        case (upper)
            "0": seg = 8'hC0;
            "1": seg = 8'hF9;
            "2": seg = 8'hA4;
            "3": seg = 8'hB0;
            "4": seg = 8'h99;
            "5": seg = 8'h92;
            "6": seg = 8'h82;
            "7": seg = 8'hF8;
            "8": seg = 8'h80;
            "9": seg = 8'h90;
            "A": seg = 8'h88;
            "B": seg = 8'h83;
            "C": seg = 8'hC6;
            "D": seg = 8'hA1;
            "E": seg = 8'h86;
            "F": seg = 8'h8E;
            "G": seg = 8'hC2;
            "H": seg = 8'h89;
            "I": seg = 8'hCF;
            "J": seg = 8'hE1;
            "K": seg = 8'h8A;
            "L": seg = 8'hC7;
            "M": seg = 8'hC8;
            "N": seg = 8'hAB;
            "O": seg = 8'hC0;
            "P": seg = 8'h8C;
            "Q": seg = 8'h98;
            "R": seg = 8'hAF;
            "S": seg = 8'h92;
            "T": seg = 8'h87;
            "U": seg = 8'hC1;
            "V": seg = 8'hE3;
            "W": seg = 8'h95;
            "X": seg = 8'h89;
            "Y": seg = 8'h91;
            "Z": seg = 8'hA4;
            "-": seg = 8'hBF;
            "_": seg = 8'hF7;
            " ": seg = 8'hFF;
            ".": seg = 8'h7F;
            default: seg = SEG_BLANK;
        endcase

        // Lower-case forms that differ from their upper-case glyph.
        case (ascii)
            "c": seg = 8'hA7;
            "h": seg = 8'h8B;
            "i": seg = 8'hFB;
            "o": seg = 8'hA3;
            "u": seg = 8'hE3;
            default: ;
        endcase
    end

endmodule

// File: rtl/seg_msg_buffer.sv
// seg_msg_buffer: loads an ASCII message over a valid/ready byte stream,
// stores it as segment patterns and presents a scrolling DIGITS-wide window.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   char_valid  - byte on char_data is offered
//   char_data   - ASCII byte
//   char_ready  - byte accepted this cycle (low only during commit)
//   step        - single-cycle scroll strobe
//   dir         - 0 = text moves left, 1 = text moves right
//   window      - segment bytes, MSB byte is the leftmost digit, 0 = lit
//   msg_len     - committed message length in cells
//   loading     - high while loading or committing (window blanked)
// Build option: SEG_MSG_PERIOD_MERGE_EN folds '.' into the decimal point of
// the previous cell instead of giving it a cell of its own.
module seg_msg_buffer
    import seg_msg_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned DIGITS  = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         char_valid,
    input  logic [7:0]                   char_data,
    output logic                         char_ready,
    input  logic                         step,
    input  logic                         dir,
    output logic [8*DIGITS-1:0]          window,
    output logic [$clog2(MAX_LEN+1)-1:0] msg_len,
    output logic                         loading
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned PTR_W = $clog2(MAX_LEN);
    // Offset and virtual length span the message plus DIGITS blank cells.
    localparam int unsigned TOT_W = $clog2(MAX_LEN + DIGITS + 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]   msg_len_q, msg_len_d;
    logic [TOT_W-1:0]   offset_q, offset_d;
    logic [8*DIGITS-1:0] window_q, window_d;
    seg_t               buf_q [MAX_LEN];

    logic               accept;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    logic               dp_clr;
    logic [PTR_W-1:0]   dp_idx;
    seg_t               font_seg;
    logic [TOT_W-1:0]   total_q;
    logic [TOT_W-1:0]   total_d;
    logic [TOT_W-1:0]   offset_step;
    logic [TOT_W:0]     virt_sum;
    logic [TOT_W:0]     virt_idx;

    seg_font u_font (
        .ascii (char_data),
        .seg   (font_seg)
    );

    assign char_ready = (state_q != StCommit);
    assign loading    = (state_q != StIdle);
    assign accept     = char_valid && char_ready;
    assign window     = window_q;
    assign msg_len    = msg_len_q;

    // Scrolled offset for the current message, wrapping over the virtual length.
    always_comb begin
        total_q = TOT_W'(msg_len_q) + TOT_W'(DIGITS);
        if (!dir) begin
            offset_step = (offset_q == total_q - TOT_W'(1)) ? '0 : offset_q + TOT_W'(1);
        end else begin
            offset_step = (offset_q == '0) ? total_q - TOT_W'(1) : offset_q - TOT_W'(1);
        end
    end

    // Load controller and scroll offset.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        msg_len_d = msg_len_q;
        offset_d  = offset_q;
        wr_en     = 1'b0;
        wr_idx    = '0;
        dp_clr    = 1'b0;
        dp_idx    = PTR_W'(wr_ptr_q - LEN_W'(1));

        unique case (state_q)
            StIdle: begin
                if (step && (msg_len_q != '0)) begin
                    offset_d = offset_step;
                end
                // First byte of a message restarts the write pointer at cell 0.
                if (accept) begin
                    if (char_data == CHAR_LF) begin
                        wr_ptr_d = '0;
                        state_d  = StCommit;
                    end else begin
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                        wr_ptr_d = LEN_W'(1);
                        state_d  = StLoad;
                    end
                end
            end

            StLoad: begin
                if (accept) begin
                    if (char_data == CHAR_LF) begin
                        state_d = StCommit;
`ifdef SEG_MSG_PERIOD_MERGE_EN
                    end else if (char_data == CHAR_PERIOD) begin
                        // In LOAD at least one cell has been written already.
                        dp_clr = 1'b1;
`endif
                    end else begin
                        wr_en    = 1'b1;
                        wr_idx   = PTR_W'(wr_ptr_q);
                        wr_ptr_d = wr_ptr_q + LEN_W'(1);
                        if (wr_ptr_q == LEN_W'(MAX_LEN - 1)) begin
                            state_d = StCommit;
                        end
                    end
                end
            end

            StCommit: begin
                msg_len_d = wr_ptr_q;
                offset_d  = '0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Window is built from next-state values so it tracks a step or commit on
    // the same edge that updates the offset, and is blank whenever loading.
    always_comb begin
        window_d = {DIGITS{SEG_BLANK}};
        total_d  = TOT_W'(msg_len_d) + TOT_W'(DIGITS);
        virt_sum = '0;
        virt_idx = '0;
        if (state_d == StIdle) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                virt_sum = {1'b0, offset_d} + (TOT_W + 1)'(k);
                virt_idx = (virt_sum >= {1'b0, total_d}) ? virt_sum - {1'b0, total_d} : virt_sum;
                if (virt_idx < (TOT_W + 1)'(msg_len_d)) begin
                    window_d[8*(int'(DIGITS) - 1 - k) +: 8] = buf_q[PTR_W'(virt_idx)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            msg_len_q <= '0;
            offset_q  <= '0;
            window_q  <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            msg_len_q <= msg_len_d;
            offset_q  <= offset_d;
            window_q  <= window_d;
        end
    end

    // Cell storage needs no reset: cells past msg_len are never displayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_idx] <= font_seg;
        end
        if (dp_clr) begin
            buf_q[dp_idx] <= buf_q[dp_idx] & ~SEG_DP_MASK;
        end
    end

endmodule

// File: doc/seg_msg_buffer.md
# seg_msg_buffer

Message source for the six-digit seven-segment scroller. Accepts an ASCII string over a valid/ready byte stream and encodes each character into an active-low `hgfedcba` segment pattern. Stores up to `MAX_LEN` cells and presents a scrolling `DIGITS`-wide window, which feeds the `hex5..hex0` outputs directly. Scroll speed is set externally by a `step` strobe from the board prescaler; scroll direction comes from a level input.

## Interface
- `MAX_LEN`, default 16: message buffer capacity in cells (2..32).
- `DIGITS`, default 6: number of display digits in the window.

- `clk`  in  1  system clock (`max10_clk1_50` at top).
- `reset`  in  1  asynchronous, active-high reset.
- `char_valid`  in  1  byte on `char_data` is offered.
- `char_data`  in  8  ASCII byte.
- `char_ready`  out  1  block accepts the byte this cycle.
- `step`  in  1  single-cycle scroll strobe.
- `dir`  in  1  0 = text moves left (offset +1); 1 = text moves right (offset −1).
- `window`  out  8*DIGITS  segment bytes; MSB byte is the leftmost digit (`hex5`); 0 = segment lit.
- `msg_len`  out  $clog2(MAX_LEN+1)  committed message length in cells.
- `loading`  out  1  high while in LOAD or COMMIT.

## Operation
- **States:** IDLE, LOAD, COMMIT.
- **IDLE:**
  - `char_ready`=1.
  - An accepted byte (`char_valid && char_ready`) enters LOAD and is processed as the first LOAD byte: write pointer reset to 0, then the byte is handled.
- **LOAD byte handling:**
  - 0x0A (LF) goes to COMMIT and is not stored.
  - Any other byte is encoded by `seg_font` and written at `wr_ptr`, then `wr_ptr` increments.
  - Writing cell `MAX_LEN-1` goes to COMMIT in the same cycle. That byte is stored.
- **COMMIT:**
  - Lasts 1 cycle with `char_ready`=0.
  - Sets `msg_len`=`wr_ptr` and `offset`=0, then returns to IDLE.
- **Blanking:** `window` is forced to all 0xFF while `loading`=1.
- **Virtual message:** the stored cells followed by `DIGITS` blank cells.
  - Length `total` = `msg_len` + `DIGITS`.
  - Window digit k (k=0 is leftmost) shows virtual index (`offset`+k) mod `total`.
  - Index < `msg_len` shows buffer[index]; any other index shows 0xFF.
- **Scrolling:**
  - `step` in IDLE with `msg_len`≠0 moves `offset`.
  - `dir`=0: `offset`+1, wrapping `total`-1 → 0.
  - `dir`=1: `offset`−1, wrapping 0 → `total`-1.
  - `step` is ignored in LOAD or COMMIT, and when `msg_len`=0.
- **Font (`seg_font`):**
  - Digits 0–9, e.g. '0'=0xC0, '1'=0xF9.
  - Letters A–Z/a–z using the displayable glyph: 'A'=0x88, 'C'=0xC6, 'E'=0x86, 'H'=0x89, 'h'=0x8B, 'I'=0xCF, 'P'=0x8C.
  - '-'=0xBF, '_'=0xF7, space=0xFF.
  - Unsupported codes map to 0xFF.
- **Empty message:** LF as the first byte commits `msg_len`=0, and the window stays all 0xFF.

## Timing
- **Reset values:** state IDLE, `char_ready`=1, `window`=all 0xFF, `msg_len`=0, `loading`=0, `offset`=0, buffer contents don't-care.
- **Registered outputs:** `window` is registered and reflects a `step` or commit on the next rising edge (1-cycle latency).
- **Handshake:**
  - A byte is accepted on an edge where `char_valid && char_ready`.
  - `char_ready` may drop only in COMMIT.
  - `char_valid` need not be held.
- **Throughput:** one byte per cycle; a message of N cells occupies N+1 cycles of LOAD/COMMIT, after the first byte.
- **Simultaneous events:** `step` coinciding with the cycle that leaves COMMIT is ignored.
- **Reset mid-load:** discards the partial message; the previous message is not restored.

## Configuration
- **`SEG_MSG_PERIOD_MERGE_EN` defined:**
  - In LOAD, '.' (0x2E) clears bit h of the most recently written cell and does not advance `wr_ptr`.
  - A '.' arriving as the first byte of a message is stored as its own cell, 0x7F.
- **`SEG_MSG_PERIOD_MERGE_EN` undefined:** '.' always occupies its own cell, 0x7F.

## Structure
- **Package `seg_msg_pkg`:**
  - `seg_t` (8-bit) and `state_t` enum.
  - Constants `SEG_BLANK`=8'hFF, `SEG_DP_MASK`=8'h80, `CHAR_LF`=8'h0A, `CHAR_PERIOD`=8'h2E.
- **Sub-module `seg_font`:** purely combinational ASCII → `seg_t` lookup, instantiated once on the write path.

## Test plan
- **Reset:** assert `reset` mid-stream → `window`=FF×6, `msg_len`=0, `char_ready`=1 with no clock edge.
- **Load:** send "ChIP\n" → `msg_len`=4; the window one cycle after COMMIT is C6 8B CF 8C FF FF.
- **Scroll left:** `dir`=0, one `step` → window 8B CF 8C FF FF FF; 10 steps → back to C6 8B CF 8C FF FF.
- **Scroll right:** `dir`=1, one `step` from `offset` 0 → `offset`=9, window FF C6 8B CF 8C FF.
- **Auto-commit:** 16 non-LF bytes with no LF → commit after the 16th; `msg_len`=16; LOAD-then-COMMIT holds `char_ready` low for exactly 1 cycle; a `step` during LOAD has no effect.
- **Period, macro on:** "1.0\n" → `msg_len`=2, cells 0x79 0xC0.
- **Period, macro off:** "1.0\n" → `msg_len`=3, cells F9 7F C0.
- **Empty message:** "\n" → `msg_len`=0, and `step` leaves the window all FF.
